// File: rtl/ram_burst_master.sv
// Burst initiator for a single-port RAM with synchronous write and combinational read.
// Commands and write beats arrive over valid/ready; read beats return over a response stream.
module ram_burst_master #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int LEN_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_last,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_q,
    output logic                  busy
);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ} state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
    localparam logic [LEN_WIDTH-1:0]  CNT_ONE  = LEN_WIDTH'(1);

    state_t                  r_state, w_state_nxt;
    logic [LEN_WIDTH-1:0]    r_cnt, w_cnt_nxt;
    logic [ADDR_WIDTH-1:0]   r_waddr, w_waddr_nxt;
    logic [ADDR_WIDTH-1:0]   r_mem_addr, w_mem_addr_nxt;
    logic [DATA_WIDTH-1:0]   r_mem_data, w_mem_data_nxt;
    logic                    r_mem_we, w_mem_we_nxt;
    logic                    r_rsp_valid, w_rsp_valid_nxt;
    logic [DATA_WIDTH-1:0]   r_rsp_data, w_rsp_data_nxt;
    logic                    r_rsp_last, w_rsp_last_nxt;
    logic                    w_slot_free;

    assign w_slot_free = !r_rsp_valid || rsp_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_waddr     <= '0;
            r_mem_addr  <= '0;
            r_mem_data  <= '0;
            r_mem_we    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_last  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_waddr     <= w_waddr_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_data  <= w_mem_data_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_data  <= w_rsp_data_nxt;
            r_rsp_last  <= w_rsp_last_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_waddr_nxt     = r_waddr;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_data_nxt  = r_mem_data;
        w_mem_we_nxt    = 1'b0;
        // A pending beat (including the last one held in IDLE) drains on rsp_ready.
        w_rsp_valid_nxt = r_rsp_valid && !rsp_ready;
        w_rsp_data_nxt  = r_rsp_data;
        w_rsp_last_nxt  = r_rsp_last;

        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    w_cnt_nxt = cmd_len;
                    if (cmd_write) begin
                        w_waddr_nxt = cmd_addr;
                        w_state_nxt = S_WRITE;
                    end else begin
                        w_mem_addr_nxt = cmd_addr;
                        w_state_nxt    = S_READ;
                    end
                end
            end
            S_WRITE: begin
                if (wr_valid) begin
                    w_mem_we_nxt   = 1'b1;
                    w_mem_addr_nxt = r_waddr;
                    w_mem_data_nxt = wr_data;
                    w_waddr_nxt    = r_waddr + ADDR_ONE;
                    w_cnt_nxt      = r_cnt - CNT_ONE;
                    if (r_cnt == '0) w_state_nxt = S_IDLE;
                end
            end
            S_READ: begin
                // mem_q reflects r_mem_addr this cycle; advancing the address only
                // when the response slot frees keeps stalls lossless.
                if (w_slot_free) begin
                    w_rsp_data_nxt  = mem_q;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_last_nxt  = (r_cnt == '0);
                    w_mem_addr_nxt  = r_mem_addr + ADDR_ONE;
                    w_cnt_nxt       = r_cnt - CNT_ONE;
                    if (r_cnt == '0) w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign cmd_ready = (r_state == S_IDLE);
    assign wr_ready  = (r_state == S_WRITE);
    assign busy      = (r_state != S_IDLE) || r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_data  = r_mem_data;
    assign mem_we    = r_mem_we;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_last  = r_rsp_last;

endmodule

// File: tb/tb_ram_burst_master.sv
// Directed bench for ram_burst_master with a behavioural single-port RAM attached.
module tb_ram_burst_master;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid, cmd_ready, cmd_write;
    logic [3:0] cmd_addr, cmd_len;
    logic       wr_valid, wr_ready;
    logic [7:0] wr_data;
    logic       rsp_valid, rsp_ready, rsp_last;
    logic [7:0] rsp_data;
    logic [3:0] mem_addr;
    logic [7:0] mem_data, mem_q;
    logic       mem_we, busy;

    int total = 0;
    int bad   = 0;

    logic [7:0] ram [16];

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_we) ram[mem_addr] <= mem_data;
    assign mem_q = ram[mem_addr];

    ram_burst_master #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .LEN_WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_last(rsp_last),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we), .mem_q(mem_q),
        .busy(busy)
    );

    typedef struct {
        logic       rst_n, cv, cw;
        logic [3:0] ca, cl;
        logic       wv;
        logic [7:0] wd;
        logic       rr;
        logic       e_crdy, e_we;
        logic [3:0] e_addr;
        logic [7:0] e_mdata;
        logic       e_rv;
        logic [7:0] e_rd;
        logic       e_rl, e_busy;
    } vec_t;

    function automatic vec_t mk(input logic r, cv, cw, input logic [3:0] ca, cl,
                                input logic wv, input logic [7:0] wd, input logic rr,
                                input logic crdy, we, input logic [3:0] addr,
                                input logic [7:0] mdata, input logic rv,
                                input logic [7:0] rd, input logic rl, bsy);
        vec_t v;
        v.rst_n = r; v.cv = cv; v.cw = cw; v.ca = ca; v.cl = cl;
        v.wv = wv; v.wd = wd; v.rr = rr;
        v.e_crdy = crdy; v.e_we = we; v.e_addr = addr; v.e_mdata = mdata;
        v.e_rv = rv; v.e_rd = rd; v.e_rl = rl; v.e_busy = bsy;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input logic v, w, input logic [3:0] a, l);
        cmd_valid = v; cmd_write = w; cmd_addr = a; cmd_len = l;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        vec_t vecs [15];
        logic [7:0] gap_exp [3];
        int we_cnt, got;

        for (int i = 0; i < 16; i++) ram[i] = 8'hC0 | 8'(i);

        //            rst cv cw ca    cl    wv wd     rr | crdy we addr  mdata  rv rd     rl busy
        vecs[0]  = mk(0, 1, 1, 4'h5, 4'h2, 0, 8'h00, 0,   1,   0, 4'h0, 8'h00, 0, 8'h00, 0, 0);
        vecs[1]  = mk(0, 1, 1, 4'h5, 4'h2, 0, 8'h00, 0,   1,   0, 4'h0, 8'h00, 0, 8'h00, 0, 0);
        vecs[2]  = mk(1, 0, 0, 4'h0, 4'h0, 0, 8'h00, 0,   1,   0, 4'h0, 8'h00, 0, 8'h00, 0, 0);
        vecs[3]  = mk(1, 1, 1, 4'hE, 4'h3, 0, 8'h00, 0,   0,   0, 4'h0, 8'h00, 0, 8'h00, 0, 1);
        vecs[4]  = mk(1, 0, 0, 4'h0, 4'h0, 1, 8'h11, 0,   0,   1, 4'hE, 8'h11, 0, 8'h00, 0, 1);
        vecs[5]  = mk(1, 0, 0, 4'h0, 4'h0, 1, 8'h22, 0,   0,   1, 4'hF, 8'h22, 0, 8'h00, 0, 1);
        vecs[6]  = mk(1, 0, 0, 4'h0, 4'h0, 1, 8'h33, 0,   0,   1, 4'h0, 8'h33, 0, 8'h00, 0, 1);
        vecs[7]  = mk(1, 0, 0, 4'h0, 4'h0, 1, 8'h44, 0,   1,   1, 4'h1, 8'h44, 0, 8'h00, 0, 1);
        vecs[8]  = mk(1, 0, 0, 4'h0, 4'h0, 1, 8'h99, 0,   1,   0, 4'h1, 8'h00, 0, 8'h00, 0, 0);
        vecs[9]  = mk(1, 1, 0, 4'hE, 4'h3, 0, 8'h00, 1,   0,   0, 4'hE, 8'h00, 0, 8'h00, 0, 1);
        vecs[10] = mk(1, 0, 0, 4'h0, 4'h0, 0, 8'h00, 1,   0,   0, 4'hF, 8'h00, 1, 8'h11, 0, 1);
        vecs[11] = mk(1, 0, 0, 4'h0, 4'h0, 0, 8'h00, 1,   0,   0, 4'h0, 8'h00, 1, 8'h22, 0, 1);
        vecs[12] = mk(1, 0, 0, 4'h0, 4'h0, 0, 8'h00, 1,   0,   0, 4'h1, 8'h00, 1, 8'h33, 0, 1);
        vecs[13] = mk(1, 0, 0, 4'h0, 4'h0, 0, 8'h00, 1,   1,   0, 4'h2, 8'h00, 1, 8'h44, 1, 0);
        vecs[14] = mk(1, 0, 0, 4'h0, 4'h0, 0, 8'h00, 1,   1,   0, 4'h2, 8'h00, 0, 8'h00, 0, 0);

        for (int i = 0; i < 15; i++) begin
            rst_n = vecs[i].rst_n;
            set_cmd(vecs[i].cv, vecs[i].cw, vecs[i].ca, vecs[i].cl);
            wr_valid = vecs[i].wv; wr_data = vecs[i].wd; rsp_ready = vecs[i].rr;
            tick();
            chk($sformatf("v%0d_cmd_ready", i), 32'(cmd_ready), 32'(vecs[i].e_crdy));
            chk($sformatf("v%0d_mem_we", i),    32'(mem_we),    32'(vecs[i].e_we));
            chk($sformatf("v%0d_mem_addr", i),  32'(mem_addr),  32'(vecs[i].e_addr));
            chk($sformatf("v%0d_rsp_valid", i), 32'(rsp_valid), 32'(vecs[i].e_rv));
            chk($sformatf("v%0d_busy", i),      32'(busy),      32'(vecs[i].e_busy));
            if (vecs[i].e_we)
                chk($sformatf("v%0d_mem_data", i), 32'(mem_data), 32'(vecs[i].e_mdata));
            if (vecs[i].e_rv) begin
                chk($sformatf("v%0d_rsp_data", i), 32'(rsp_data), 32'(vecs[i].e_rd));
                chk($sformatf("v%0d_rsp_last", i), 32'(rsp_last), 32'(vecs[i].e_rl));
            end
        end

        // Backpressure after the second beat of a wrapping read
        wr_valid = 0;
        set_cmd(1, 0, 4'hE, 4'h3); rsp_ready = 1;
        tick();
        set_cmd(0, 0, 4'h0, 4'h0);
        tick(); chk("bp_b0", 32'(rsp_data), 32'h11);
        tick(); chk("bp_b1", 32'(rsp_data), 32'h22);
        rsp_ready = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("bp_hold_valid%0d", k), 32'(rsp_valid), 32'h1);
            chk($sformatf("bp_hold_data%0d", k),  32'(rsp_data),  32'h22);
            chk($sformatf("bp_hold_addr%0d", k),  32'(mem_addr),  32'h0);
        end
        rsp_ready = 1;
        tick(); chk("bp_b2", 32'(rsp_data), 32'h33); chk("bp_b2_last", 32'(rsp_last), 32'h0);
        tick(); chk("bp_b3", 32'(rsp_data), 32'h44); chk("bp_b3_last", 32'(rsp_last), 32'h1);

        // Last beat held in IDLE while a new single-beat read is accepted
        rsp_ready = 0;
        chk("pend_cmd_ready", 32'(cmd_ready), 32'h1);
        set_cmd(1, 0, 4'h0, 4'h0);
        tick();
        set_cmd(0, 0, 4'h0, 4'h0);
        chk("pend_hold_data", 32'(rsp_data), 32'h44);
        chk("pend_hold_valid", 32'(rsp_valid), 32'h1);
        chk("pend_in_read", 32'(cmd_ready), 32'h0);
        tick();
        chk("pend_stall_data", 32'(rsp_data), 32'h44);
        chk("pend_stall_addr", 32'(mem_addr), 32'h0);
        rsp_ready = 1;
        tick();
        chk("pend_new_data", 32'(rsp_data), 32'h33);
        chk("pend_new_last", 32'(rsp_last), 32'h1);
        tick();
        chk("pend_drained", 32'(rsp_valid), 32'h0);

        // Write with gaps: wr_valid 1,0,0,1,1
        gap_exp[0] = 8'hA1; gap_exp[1] = 8'hA2; gap_exp[2] = 8'hA3;
        set_cmd(1, 1, 4'h3, 4'h2);
        tick();
        set_cmd(0, 0, 4'h0, 4'h0);
        we_cnt = 0;
        for (int k = 0; k < 7; k++) begin
            case (k)
                0: begin wr_valid = 1; wr_data = 8'hA1; end
                3: begin wr_valid = 1; wr_data = 8'hA2; end
                4: begin wr_valid = 1; wr_data = 8'hA3; end
                default: begin wr_valid = 0; wr_data = 8'hEE; end
            endcase
            tick();
            if (mem_we) begin
                if (we_cnt < 3) begin
                    chk($sformatf("gap_addr%0d", we_cnt), 32'(mem_addr), 32'(3 + we_cnt));
                    chk($sformatf("gap_data%0d", we_cnt), 32'(mem_data), 32'(gap_exp[we_cnt]));
                end
                we_cnt++;
            end
        end
        chk("gap_we_count", 32'(we_cnt), 32'd3);
        wr_valid = 0;

        set_cmd(1, 0, 4'h3, 4'h2);
        tick();
        set_cmd(0, 0, 4'h0, 4'h0);
        got = 0;
        for (int c = 0; c < 12 && got < 3; c++) begin
            tick();
            if (rsp_valid) begin
                chk($sformatf("rb_data%0d", got), 32'(rsp_data), 32'(gap_exp[got]));
                chk($sformatf("rb_last%0d", got), 32'(rsp_last), 32'(got == 2));
                got++;
            end
        end
        chk("rb_beats", 32'(got), 32'd3);
        tick();

        // Reset during a long read
        set_cmd(1, 0, 4'h0, 4'h7);
        tick();
        set_cmd(0, 0, 4'h0, 4'h0);
        tick();
        chk("mr_first_valid", 32'(rsp_valid), 32'h1);
        chk("mr_first_data", 32'(rsp_data), 32'h33);
        rst_n = 0;
        tick();
        chk("mr_rst_valid", 32'(rsp_valid), 32'h0);
        chk("mr_rst_ready", 32'(cmd_ready), 32'h1);
        chk("mr_rst_busy",  32'(busy), 32'h0);
        rst_n = 1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("mr_quiet%0d", k), 32'(rsp_valid), 32'h0);
        end
        set_cmd(1, 0, 4'h3, 4'h1);
        tick();
        set_cmd(0, 0, 4'h0, 4'h0);
        tick();
        chk("mr_fresh0", 32'(rsp_data), 32'hA1); chk("mr_fresh0_last", 32'(rsp_last), 32'h0);
        tick();
        chk("mr_fresh1", 32'(rsp_data), 32'hA2); chk("mr_fresh1_last", 32'(rsp_last), 32'h1);
        tick();
        chk("mr_end_idle", 32'(cmd_ready), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_burst_master.md
Name: ram_burst_master

Overview:
Initiator-side controller for the team's single-port synchronous-write / combinational-read RAM. It accepts burst commands over a valid/ready interface and takes write data from a stream. It drives the RAM's addr/data/we pins, samples the RAM's q output, and returns read data over a valid/ready response stream. It sits between a DMA/test client and one single-port RAM instance.

Parameters:
DATA_WIDTH, 8, width of RAM data, write-stream data and response data
ADDR_WIDTH, 4, RAM address width; RAM depth 2**ADDR_WIDTH
LEN_WIDTH, 4, width of burst length field; burst = cmd_len+1 beats (1..2**LEN_WIDTH)

Ports:
clk  in  1  clock, all state updates on posedge
rst_n  in  1  reset, synchronous, active-low
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready; equals (state==IDLE)
cmd_write  in  1  1=write burst, 0=read burst
cmd_addr  in  ADDR_WIDTH  burst start address
cmd_len  in  LEN_WIDTH  beats minus one
wr_valid  in  1  write beat offered
wr_ready  out  1  equals (state==WRITE)
wr_data  in  DATA_WIDTH  write beat data
rsp_valid  out  1  read beat available
rsp_ready  in  1  consumer accepts read beat
rsp_data  out  DATA_WIDTH  read beat data
rsp_last  out  1  marks final beat of a read burst
mem_addr  out  ADDR_WIDTH  to RAM addr
mem_data  out  DATA_WIDTH  to RAM data
mem_we  out  1  to RAM we
mem_q  in  DATA_WIDTH  from RAM q; valid only while mem_we=0
busy  out  1  (state!=IDLE) || mem_we

Behaviour:
- Reset (rst_n low at posedge): state=IDLE; mem_we=0, mem_addr=0, mem_data=0, rsp_valid=0, rsp_data=0, rsp_last=0; beat counter=0. Afterwards cmd_ready=1 and busy=0. Reset overrides all other events.
- mem_addr, mem_data, mem_we, rsp_* are registered. cmd_ready, wr_ready and busy are combinational from registered state.
- FSM states: IDLE, WRITE, READ.
- IDLE:
  - On cmd handshake, latch the remaining-beat count = cmd_len.
  - cmd_write=1: latch write address = cmd_addr; go to WRITE.
  - cmd_write=0: mem_addr<=cmd_addr, mem_we<=0; go to READ.
- WRITE:
  - Each cycle with wr_valid: mem_we<=1, mem_addr<=write address, mem_data<=wr_data; write address +1; count -1.
  - Cycle without wr_valid: mem_we<=0, so no spurious write.
  - Beat accepted with count==0: go to IDLE.
  - The RAM commits each beat at the posedge after it was registered. The last beat commits during the first IDLE cycle, before any following read can sample, so there is no read-after-write hazard.
  - mem_q is never sampled in WRITE.
- READ:
  - Slot free = !rsp_valid || rsp_ready.
  - Each cycle with slot free: rsp_data<=mem_q, rsp_valid<=1, rsp_last<=(count==0), mem_addr<=mem_addr+1, count -1. If count==0, go to IDLE.
  - Slot not free: hold mem_addr, rsp_data, rsp_valid and rsp_last (stall, no loss or duplication).
- Outside READ: rsp_valid clears on rsp_ready; the last beat stays held in IDLE until accepted. A new command may be accepted while it is pending.
- Read latency: cmd handshake in cycle N gives the first rsp_valid in cycle N+2. With rsp_ready held high, one beat per cycle.
- Write throughput: one beat per cycle with wr_valid held high.
- Address arithmetic: modulo 2**ADDR_WIDTH, so bursts wrap from max to 0. Counter arithmetic is unsigned in LEN_WIDTH.
- mem_we is 0 whenever not in WRITE after the last registered beat, so the RAM drives q only during reads.
- Reset mid-burst: the burst is aborted and no further beats issue or return. A write beat registered before the reset edge still commits at that edge because the RAM has no reset. Any pending rsp is dropped.
- Bus values on wr_data/cmd_* are ignored when the corresponding handshake is not taken.

Test Plan:
(DATA_WIDTH=8, ADDR_WIDTH=4, LEN_WIDTH=4)
- Reset: rst_n=0 for 2 cycles with cmd_valid=1 -> no handshake; after release cmd_ready=1, mem_we=0, rsp_valid=0, busy=0.
- Write wrap: cmd write addr=0xE len=3, wr_data 0x11,0x22,0x33,0x44 back-to-back -> mem_we=1 for 4 consecutive cycles at mem_addr E,F,0,1; then cmd_ready=1.
- Read wrap: read addr=0xE len=3, rsp_ready=1, handshake cycle N -> rsp_data 0x11,0x22,0x33,0x44 in cycles N+2..N+5; rsp_last only on 0x44.
- Backpressure: same read with rsp_ready=0 for 3 cycles after the 2nd beat -> rsp_data holds 0x22 and mem_addr is stable; the burst then resumes with 0x33,0x44, no gaps or duplicates.
- Write gaps: len=2 with wr_valid pattern 1,0,0,1,1 -> exactly 3 cycles with mem_we=1; read-back returns the 3 values in order.
- Reset mid-read: reset asserted after the 1st rsp beat of a len=7 read -> next cycle rsp_valid=0, state IDLE, no further beats; a fresh read returns correct data.
